cu_vertex_read_responder: RTL and testbench

Local read responder on the compute-unit read path. It accepts `CommandBufferLine` read commands, services them from an on-chip vertex scratchpad, and returns each cacheline as two `ReadWriteDataLine` halves followed by one `ResponseBufferLine` completion. These are the same beat formats a requesting CU or vertex cache expects from the host memory path. The block is used as the memory-side endpoint for vertex data, either as a fast path for hot vertices or as a stand-in endpoint on the bench.

---
 rtl/cu_vertex_read_responder_pkg.sv | 63 ++++++
 rtl/cu_vertex_responder_cmd_fifo.sv | 70 +++++++
 rtl/cu_vertex_read_responder.sv | 129 ++++++++++++
 tb/tb_cu_vertex_read_responder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_vertex_read_responder_pkg.sv
// Shared types for the compute-unit vertex read responder: command, data and
// response beat formats, FIFO status, and the responder state encoding.
package cu_vertex_read_responder_pkg;

  localparam int CACHELINE_BYTES       = 128;
  localparam int CACHELINE_OFFSET_BITS = $clog2(CACHELINE_BYTES);
  localparam int HALF_LINE_BITS        = 512;
  localparam int LINE_BITS             = 2 * HALF_LINE_BITS;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    SEND_D0,
    SEND_D1,
    SEND_RSP
  } ResponderState;

  typedef enum logic [1:0] {
    NOP    = 2'd0,
    DONE   = 2'd1,
    AERROR = 2'd2
  } ResponseType;

  typedef struct packed {
    logic [7:0]  cu_id;
    logic [15:0] tag;
  } CommandTag;

  typedef struct packed {
    logic        valid;
    logic [63:0] address;
    CommandTag   cmd;
    logic [7:0]  size;
  } CommandBufferLine;

  typedef struct packed {
    logic                      valid;
    logic [HALF_LINE_BITS-1:0] data;
    CommandTag                 cmd;
  } ReadWriteDataLine;

  typedef struct packed {
    logic        valid;
    CommandTag   cmd;
    ResponseType response;
  } ResponseBufferLine;

  typedef struct packed {
    logic empty;
    logic full;
    logic alfull;
  } BufferStatus;

  // Almost-full leaves two slots of headroom for producers with a short pipeline.
  function automatic BufferStatus fifo_status(input int occupancy, input int depth);
    BufferStatus s;
    s.empty  = (occupancy == 0);
    s.full   = (occupancy >= depth);
    s.alfull = (occupancy >= depth - 2);
    return s;
  endfunction

endpackage

// File: rtl/cu_vertex_responder_cmd_fifo.sv
// Synchronous FIFO of read commands with registered status; a pop in the same
// cycle frees a slot so a push to a full FIFO is still accepted.
module cu_vertex_responder_cmd_fifo
  import cu_vertex_read_responder_pkg::*;
#(
  parameter int CMD_FIFO_DEPTH = 8
) (
  input  logic             clock,
  input  logic             rst_in,
  input  logic             push,
  input  CommandBufferLine push_data,
  input  logic             pop,
  output CommandBufferLine head,
  output logic             not_empty,
  output logic             dropped,
  output BufferStatus      status
);

  localparam int PTR_W = $clog2(CMD_FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_COUNT = (PTR_W + 1)'(CMD_FIFO_DEPTH);

  CommandBufferLine mem [CMD_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_next;
  logic             do_push;
  logic             do_pop;

  assign not_empty = (count != '0);
  assign do_pop    = pop && not_empty;
  assign do_push   = push && ((count != DEPTH_COUNT) || do_pop);
  assign dropped   = push && !do_push;
  assign head      = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + (PTR_W + 1)'(1);
    end else if (!do_push && do_pop) begin
      count_next = count - (PTR_W + 1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      status <= '{empty: 1'b1, full: 1'b0, alfull: 1'b0};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count  <= count_next;
      status <= fifo_status(32'(count_next), CMD_FIFO_DEPTH);
    end
  end

  // Storage is left unreset; entries are only observed once written.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/cu_vertex_read_responder.sv
// Memory-side endpoint for vertex reads: queues commands, reads a scratchpad
// line, and returns two data halves followed by a completion.
module cu_vertex_read_responder
  import cu_vertex_read_responder_pkg::*;
#(
  parameter int          CMD_FIFO_DEPTH = 8,
  parameter int          SCRATCH_LINES  = 256,
  parameter logic [63:0] BASE_ADDRESS   = 64'd0
) (
  input  logic                             clock,
  input  logic                             rst_in,
  input  logic                             enabled_in,
  input  CommandBufferLine                 read_command_in,
  input  logic                             fill_valid_in,
  input  logic [$clog2(SCRATCH_LINES)-1:0] fill_index_in,
  input  logic [HALF_LINE_BITS-1:0]        fill_data_0_in,
  input  logic [HALF_LINE_BITS-1:0]        fill_data_1_in,
  output BufferStatus                      read_buffer_status_out,
  output ReadWriteDataLine                 read_data_0_out,
  output ReadWriteDataLine                 read_data_1_out,
  output ResponseBufferLine                read_response_out,
  output logic                             overflow_error_out
);

  localparam int          INDEX_W       = $clog2(SCRATCH_LINES);
  localparam logic [63:0] SCRATCH_BYTES = 64'(SCRATCH_LINES) * 64'(CACHELINE_BYTES);

  ResponderState    state;
  CommandBufferLine fifo_head;
  logic             fifo_not_empty;
  logic             fifo_dropped;
  logic             fifo_pop;

  logic [63:0]        cmd_address;
  CommandTag          cmd_tag;
  logic [63:0]        offset;
  logic               in_range;
  logic [INDEX_W-1:0] lookup_index;

  logic [LINE_BITS-1:0] scratch [SCRATCH_LINES];
  logic [LINE_BITS-1:0] line_q;

  logic unused_head_bits;
  assign unused_head_bits = ^{fifo_head.valid, fifo_head.size};

  cu_vertex_responder_cmd_fifo #(
    .CMD_FIFO_DEPTH(CMD_FIFO_DEPTH)
  ) u_cmd_fifo (
    .clock     (clock),
    .rst_in    (rst_in),
    .push      (read_command_in.valid),
    .push_data (read_command_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .not_empty (fifo_not_empty),
    .dropped   (fifo_dropped),
    .status    (read_buffer_status_out)
  );

  // A new command is taken from IDLE, or straight from SEND_RSP for back-to-back service.
  assign fifo_pop = ((state == IDLE) || (state == SEND_RSP)) && enabled_in && fifo_not_empty;

  assign offset       = cmd_address - BASE_ADDRESS;
  assign in_range     = (cmd_address >= BASE_ADDRESS) && (offset < SCRATCH_BYTES);
  assign lookup_index = offset[CACHELINE_OFFSET_BITS +: INDEX_W];

  // Read-first RAM: a fill landing on the line being looked up returns the old contents.
  always_ff @(posedge clock) begin
    if (fill_valid_in) begin
      scratch[fill_index_in] <= {fill_data_1_in, fill_data_0_in};
    end
    if (state == LOOKUP) begin
      line_q <= scratch[lookup_index];
    end
  end

  always_ff @(posedge clock) begin
    if (rst_in) begin
      state              <= IDLE;
      cmd_address        <= '0;
      cmd_tag            <= '0;
      read_data_0_out    <= '0;
      read_data_1_out    <= '0;
      read_response_out  <= '0;
      overflow_error_out <= 1'b0;
    end else begin
      read_data_0_out   <= '0;
      read_data_1_out   <= '0;
      read_response_out <= '0;

      if (fifo_dropped) begin
        overflow_error_out <= 1'b1;
      end

      if (fifo_pop) begin
        cmd_address <= fifo_head.address;
        cmd_tag     <= fifo_head.cmd;
      end

      unique case (state)
        IDLE: begin
          if (fifo_pop) begin
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          state <= in_range ? SEND_D0 : SEND_RSP;
        end
        SEND_D0: begin
          read_data_0_out <= '{valid: 1'b1, data: line_q[HALF_LINE_BITS-1:0], cmd: cmd_tag};
          state           <= SEND_D1;
        end
        SEND_D1: begin
          read_data_1_out <= '{valid: 1'b1, data: line_q[LINE_BITS-1:HALF_LINE_BITS], cmd: cmd_tag};
          state           <= SEND_RSP;
        end
        SEND_RSP: begin
          read_response_out <= '{valid: 1'b1, cmd: cmd_tag,
                                 response: (in_range ? DONE : AERROR)};
          state             <= fifo_pop ? LOOKUP : IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cu_vertex_read_responder.sv
// Directed scoreboard bench for cu_vertex_read_responder: expected beats and
// their arrival edges are queued at issue time and matched as outputs appear.
module tb_cu_vertex_read_responder;
  import cu_vertex_read_responder_pkg::*;

  localparam int          DEPTH = 8;
  localparam int          LINES = 256;
  localparam logic [63:0] BASE  = 64'h0000_0000_0001_0000;

  localparam BufferStatus ST_EMPTY = '{empty: 1'b1, full: 1'b0, alfull: 1'b0};
  localparam BufferStatus ST_FULL  = '{empty: 1'b0, full: 1'b1, alfull: 1'b1};

  logic                      clock;
  logic                      rst_in;
  logic                      enabled_in;
  CommandBufferLine          read_command_in;
  logic                      fill_valid_in;
  logic [7:0]                fill_index_in;
  logic [HALF_LINE_BITS-1:0] fill_data_0_in;
  logic [HALF_LINE_BITS-1:0] fill_data_1_in;
  BufferStatus               read_buffer_status_out;
  ReadWriteDataLine          read_data_0_out;
  ReadWriteDataLine          read_data_1_out;
  ResponseBufferLine         read_response_out;
  logic                      overflow_error_out;

  typedef struct {
    int                        kind;
    logic [HALF_LINE_BITS-1:0] data;
    CommandTag                 cmd;
    ResponseType               resp;
    int                        cycle;
  } Expected;

  Expected sb[$];
  int compared   = 0;
  int mismatched = 0;
  int edge_count = 0;
  int next_pop   = 0;
  logic [HALF_LINE_BITS-1:0] shadow0 [LINES];
  logic [HALF_LINE_BITS-1:0] shadow1 [LINES];

  cu_vertex_read_responder #(
    .CMD_FIFO_DEPTH(DEPTH),
    .SCRATCH_LINES (LINES),
    .BASE_ADDRESS  (BASE)
  ) dut (
    .clock                  (clock),
    .rst_in                 (rst_in),
    .enabled_in             (enabled_in),
    .read_command_in        (read_command_in),
    .fill_valid_in          (fill_valid_in),
    .fill_index_in          (fill_index_in),
    .fill_data_0_in         (fill_data_0_in),
    .fill_data_1_in         (fill_data_1_in),
    .read_buffer_status_out (read_buffer_status_out),
    .read_data_0_out        (read_data_0_out),
    .read_data_1_out        (read_data_1_out),
    .read_response_out      (read_response_out),
    .overflow_error_out     (overflow_error_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) edge_count <= edge_count + 1;

  task automatic check_output(input string name, input logic [1023:0] observed,
                              input logic [1023:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  function automatic logic [HALF_LINE_BITS-1:0] rand_half();
    logic [HALF_LINE_BITS-1:0] r;
    for (int i = 0; i < HALF_LINE_BITS / 32; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  // Service model: a command pops one edge after its push or when the previous one retires.
  task automatic model_push(input logic [63:0] addr, input CommandTag tagv, input int n);
    int p;
    int idx;
    logic [63:0] off;
    Expected e;
    p = (n + 1 > next_pop) ? n + 1 : next_pop;
    e.cmd = tagv;
    if (addr >= BASE && (addr - BASE) < 64'(LINES * CACHELINE_BYTES)) begin
      off = addr - BASE;
      idx = int'(off >> 7);
      e.kind = 0; e.data = shadow0[idx]; e.resp = NOP;  e.cycle = p + 2; sb.push_back(e);
      e.kind = 1; e.data = shadow1[idx]; e.resp = NOP;  e.cycle = p + 3; sb.push_back(e);
      e.kind = 2; e.data = '0;           e.resp = DONE; e.cycle = p + 4; sb.push_back(e);
      next_pop = p + 4;
    end else begin
      e.kind = 2; e.data = '0; e.resp = AERROR; e.cycle = p + 2; sb.push_back(e);
      next_pop = p + 2;
    end
  endtask

  task automatic issue_read(input logic [63:0] addr, input logic [15:0] tag,
                            input logic [7:0] cu, input bit accepted);
    int n;
    CommandBufferLine c;
    CommandTag t;
    n = edge_count + 1;
    t.cu_id = cu;
    t.tag = tag;
    c.valid = 1'b1;
    c.address = addr;
    c.cmd = t;
    c.size = 8'd128;
    read_command_in = c;
    if (accepted) model_push(addr, t, n);
    @(posedge clock);
    #1 read_command_in = '0;
  endtask

  task automatic fill_line(input int idx, input logic [HALF_LINE_BITS-1:0] d0,
                           input logic [HALF_LINE_BITS-1:0] d1);
    fill_valid_in  = 1'b1;
    fill_index_in  = 8'(idx);
    fill_data_0_in = d0;
    fill_data_1_in = d1;
    @(posedge clock);
    #1 fill_valid_in = 1'b0;
    shadow0[idx] = d0;
    shadow1[idx] = d1;
  endtask

  task automatic drain(input string name);
    int waited;
    waited = 0;
    while (sb.size() != 0 && waited < 200) begin
      @(posedge clock);
      waited++;
    end
    @(negedge clock);
    check_output({name, "_drained"}, 1024'(sb.size()), 1024'(0));
    if (sb.size() != 0) sb.delete();
    repeat (2) @(posedge clock);
    #1;
  endtask

  // Output monitor: every valid beat must match the oldest expectation, including its edge.
  always @(negedge clock) begin
    int nv;
    int kind_obs;
    logic [HALF_LINE_BITS-1:0] data_obs;
    CommandTag cmd_obs;
    Expected e;
    nv = int'(read_data_0_out.valid) + int'(read_data_1_out.valid) + int'(read_response_out.valid);
    if (nv != 0) begin
      if (nv > 1) check_output("one_beat_per_cycle", 1024'(nv), 1024'(1));
      if (sb.size() == 0) begin
        check_output("unexpected_beat", 1024'(nv), 1024'(0));
      end else begin
        e = sb.pop_front();
        if (read_data_0_out.valid) begin
          kind_obs = 0; data_obs = read_data_0_out.data; cmd_obs = read_data_0_out.cmd;
        end else if (read_data_1_out.valid) begin
          kind_obs = 1; data_obs = read_data_1_out.data; cmd_obs = read_data_1_out.cmd;
        end else begin
          kind_obs = 2; data_obs = '0; cmd_obs = read_response_out.cmd;
        end
        check_output("beat_kind", 1024'(kind_obs), 1024'(e.kind));
        check_output("beat_edge", 1024'(edge_count), 1024'(e.cycle));
        check_output("beat_cmd", 1024'(cmd_obs), 1024'(e.cmd));
        if (e.kind < 2) check_output("beat_data", 1024'(data_obs), 1024'(e.data));
        else check_output("rsp_code", 1024'(read_response_out.response), 1024'(e.resp));
      end
    end
  end

  initial begin
    logic [HALF_LINE_BITS-1:0] a_pat;
    logic [HALF_LINE_BITS-1:0] b_pat;
    logic [HALF_LINE_BITS-1:0] new0;
    logic [HALF_LINE_BITS-1:0] new1;
    int start_edge;

    rst_in          = 1'b1;
    enabled_in      = 1'b1;
    read_command_in = '0;
    fill_valid_in   = 1'b0;
    fill_index_in   = '0;
    fill_data_0_in  = '0;
    fill_data_1_in  = '0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_output("reset_d0", 1024'(read_data_0_out), 1024'(0));
    check_output("reset_d1", 1024'(read_data_1_out), 1024'(0));
    check_output("reset_rsp", 1024'(read_response_out), 1024'(0));
    check_output("reset_status", 1024'(read_buffer_status_out), 1024'(ST_EMPTY));
    check_output("reset_overflow", 1024'(overflow_error_out), 1024'(0));
    rst_in = 1'b0;
    @(posedge clock);
    #1;

    for (int i = 0; i < 8; i++) fill_line(i, rand_half(), rand_half());
    a_pat = {(HALF_LINE_BITS / 4){4'hA}};
    b_pat = {(HALF_LINE_BITS / 4){4'hB}};
    fill_line(5, a_pat, b_pat);

    $display("[TB] single in-range read of line 5");
    issue_read(BASE + 64'h280, 16'h11, 8'h02, 1'b1);
    drain("single_read");

    $display("[TB] out-of-range reads above and below the window");
    issue_read(BASE + 64'(LINES * CACHELINE_BYTES), 16'h22, 8'h03, 1'b1);
    issue_read(BASE - 64'h80, 16'h23, 8'h03, 1'b1);
    drain("out_of_range");

    $display("[TB] back-to-back reads");
    for (int i = 0; i < 4; i++) issue_read(BASE + 64'(i * CACHELINE_BYTES), 16'(16'h30 + i), 8'h04, 1'b1);
    drain("back_to_back");
    check_output("b2b_no_overflow", 1024'(overflow_error_out), 1024'(0));

    $display("[TB] overflow with service disabled");
    enabled_in = 1'b0;
    start_edge = edge_count;
    next_pop   = start_edge + 11;
    for (int i = 0; i < 9; i++) issue_read(BASE + 64'((i % 8) * CACHELINE_BYTES), 16'(16'h60 + i), 8'h05, i < 8);
    @(negedge clock);
    check_output("ovf_status_full", 1024'(read_buffer_status_out), 1024'(ST_FULL));
    check_output("ovf_flag", 1024'(overflow_error_out), 1024'(1));
    @(posedge clock);
    #1 enabled_in = 1'b1;
    drain("overflow");
    check_output("ovf_status_empty", 1024'(read_buffer_status_out), 1024'(ST_EMPTY));
    check_output("ovf_sticky", 1024'(overflow_error_out), 1024'(1));

    $display("[TB] fill collides with lookup of line 3");
    new0 = rand_half();
    new1 = rand_half();
    issue_read(BASE + 64'(3 * CACHELINE_BYTES), 16'h40, 8'h06, 1'b1);
    @(posedge clock);
    #1;
    fill_line(3, new0, new1);
    drain("collision_old");
    issue_read(BASE + 64'(3 * CACHELINE_BYTES), 16'h41, 8'h06, 1'b1);
    drain("collision_new");

    $display("[TB] reset between data halves");
    issue_read(BASE + 64'h280, 16'h50, 8'h07, 1'b1);
    repeat (3) @(posedge clock);
    #1 rst_in = 1'b1;
    @(posedge clock);
    sb.delete();
    next_pop = 0;
    #1 rst_in = 1'b0;
    @(negedge clock);
    check_output("midrst_d0", 1024'(read_data_0_out), 1024'(0));
    check_output("midrst_d1", 1024'(read_data_1_out), 1024'(0));
    check_output("midrst_rsp", 1024'(read_response_out), 1024'(0));
    check_output("midrst_status", 1024'(read_buffer_status_out), 1024'(ST_EMPTY));
    check_output("midrst_overflow", 1024'(overflow_error_out), 1024'(0));
    repeat (8) @(posedge clock);
    #1;
    issue_read(BASE + 64'h280, 16'h51, 8'h07, 1'b1);
    drain("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
